// File: rtl/rom_pkg.sv
// Shared types and defaults for the ROM byte streamer.
package rom_pkg;

    localparam int ROM_ADDR_W     = 10;
    localparam int ROM_FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/stream_fifo.sv
// Small power-of-two FIFO buffering ROM bytes toward the output stream.
module stream_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = wdata;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata = mem_q[rd_q];
    assign count = cnt_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/rom_streamer.sv
// Streams len bytes from a 1-cycle-latency ROM starting at base.
// Define ROM_CHECKSUM_EN to add a 16-bit running checksum output.
module rom_streamer
    import rom_pkg::*;
#(
    parameter int ADDR_W     = ROM_ADDR_W,
    parameter int FIFO_DEPTH = ROM_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              res_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_A,
    output logic              rom_enable,
    input  logic              rom_OE,
    input  logic [7:0]        rom_DO,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              out_last
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic                pend_q, pend_d;
    logic                pend_last_q, pend_last_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;

    logic                accept;
    logic                retry;
    logic                push;
    logic                pop;
    logic                issue;
    logic                last_issue;
    logic [CW:0]         occ;
    logic [8:0]          rdata;
    logic [CW-1:0]       count;
    logic                empty;

    stream_fifo #(
        .W     (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .res_n (res_n),
        .push  (push),
        .wdata ({pend_last_q, rom_DO}),
        .pop   (pop),
        .rdata (rdata),
        .count (count),
        .empty (empty)
    );

    // Occupancy counts in-flight reads so a response always finds room.
    always_comb begin
        accept     = (state_q == S_IDLE) && start;
        retry      = pend_q && !rom_OE;
        push       = pend_q && rom_OE;
        pop        = !empty && out_ready;
        occ        = (CW+1)'(count) + (CW+1)'(pend_q) - (CW+1)'(pop);
        issue      = (state_q == S_READ) && (remain_q != '0) && !retry
                     && (occ < (CW+1)'(FIFO_DEPTH));
        last_issue = issue && (remain_q == (ADDR_W+1)'(1));
    end

    always_comb begin
        addr_d      = addr_q;
        remain_d    = remain_q;
        pend_d      = issue || retry;
        pend_last_d = pend_last_q;
        pend_addr_d = pend_addr_q;
        if (accept) begin
            addr_d   = base;
            remain_d = len;
        end
        if (issue) begin
            addr_d      = addr_q + 1'b1;
            remain_d    = remain_q - 1'b1;
            pend_addr_d = addr_q;
            pend_last_d = (remain_q == (ADDR_W+1)'(1));
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pend_q && (empty || (count == CW'(1) && pop))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remain_q    <= remain_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    always_comb begin
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        rom_enable = issue || pend_q;
        rom_A      = retry ? pend_addr_q : addr_q;
        out_valid  = !empty;
        out_data   = empty ? 8'h00 : rdata[7:0];
        out_last   = !empty && rdata[8];
    end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (accept) begin
            sum_d = '0;
        end else if (pop) begin
            sum_d = sum_q + {8'h00, out_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_rom_streamer.sv
// Directed and randomized dumps checked against a queue-based ROM model.
module tb_rom_streamer;

    logic        clk = 1'b0;
    logic        res_n;
    logic        start;
    logic [9:0]  base;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [9:0]  rom_A;
    logic        rom_enable;
    logic        rom_OE;
    logic [7:0]  rom_DO;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
`ifdef ROM_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    logic [7:0]  mem [1024];
    logic        rd_v = 1'b0;
    logic [7:0]  rom_q = 8'h00;
    logic        oe_gate = 1'b1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rom_streamer dut (
        .clk        (clk),
        .res_n      (res_n),
        .start      (start),
        .base       (base),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rom_A      (rom_A),
        .rom_enable (rom_enable),
        .rom_OE     (rom_OE),
        .rom_DO     (rom_DO),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
`ifdef ROM_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // Behavioural ROM: data for the address seen at an edge appears next cycle.
    always @(posedge clk) begin
        rd_v  <= rom_enable;
        rom_q <= mem[rom_A];
    end
    assign rom_DO = rom_q;
    assign rom_OE = rd_v & oe_gate;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_ctl"}, {busy, done, out_valid, out_last, rom_enable}, 0);
        check({tag, "_rom_A"}, rom_A, 0);
        check({tag, "_data"}, out_data, 0);
    endtask

    // rmode: 0 ready high, 1 toggle, 2 random. omode: 0 OE high, 1 random.
    task automatic run_dump(input logic [9:0] b, input logic [10:0] l,
                            input int rmode, input int omode,
                            input int rst_at, input bit chk_lat);
        logic [8:0] q[$];
        logic [8:0] w;
        logic [8:0] pv_word;
        bit         pv_hold;
        bit         did_rst;
        int         cyc, n_acc, last_i, done_i, first_v, budget;
        for (int i = 0; i < int'(l); i++) begin
            w = {(i == int'(l) - 1), mem[10'(int'(b) + i)]};
            q.push_back(w);
        end
        budget  = 8 * int'(l) + 40;
        cyc     = 0;
        n_acc   = 0;
        last_i  = -1;
        done_i  = -1;
        first_v = -1;
        pv_hold = 0;
        pv_word = '0;
        did_rst = 0;
        @(negedge clk);
        start     = 1'b1;
        base      = b;
        len       = l;
        out_ready = 1'b1;
        oe_gate   = 1'b1;
        #1;
        check("busy_pre", busy, 0);
        while (done_i < 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            base  = $urandom;
            len   = 11'($urandom);
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2) == 1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            oe_gate = (omode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (cyc == 1) check("busy_run", busy, 1);
            if (pv_hold) begin
                check("stable", {out_valid, out_last, out_data}, {1'b1, pv_word});
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (rst_at > 0 && n_acc == rst_at - 1 && out_valid) begin
                res_n   = 1'b0;
                did_rst = 1;
                break;
            end
            if (done) done_i = cyc;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("extra_byte", out_valid, 0);
                end else begin
                    w = q.pop_front();
                    check("data", out_data, w[7:0]);
                    check("last", out_last, w[8]);
                    if (q.size() == 0) last_i = cyc;
                end
                n_acc++;
            end
            pv_hold = out_valid && !out_ready;
            pv_word = {out_last, out_data};
        end
        if (did_rst) begin
            @(negedge clk);
            out_ready = 1'b1;
            oe_gate   = 1'b1;
            #1;
            check_idle_zero("mid_rst");
            res_n = 1'b1;
            repeat (3) begin
                @(negedge clk);
                #1;
                check("no_valid_after_rst", out_valid, 0);
            end
        end else begin
            check("timeout", (done_i >= 0), 1);
            check("byte_count", n_acc, l);
            if (l == 0) begin
                check("done_at", done_i, 1);
                check("no_valid", first_v, 32'hffff_ffff);
            end else begin
                check("done_at", done_i, last_i + 1);
                if (chk_lat) check("latency", first_v, 3);
            end
            @(negedge clk);
            #1;
            check("done_pulse", done, 0);
            check("busy_end", busy, 0);
        end
    endtask

    initial begin
        int s;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        res_n     = 1'b0;
        start     = 1'b0;
        base      = '0;
        len       = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_zero("reset");
`ifdef ROM_CHECKSUM_EN
        check("reset_checksum", checksum, 0);
`endif
        res_n = 1'b1;

        run_dump(10'h000, 11'd4, 0, 0, 0, 1);
        run_dump(10'h3FE, 11'd4, 0, 0, 0, 1);
        run_dump(10'($urandom), 11'd16, 1, 0, 0, 0);
        run_dump(10'($urandom), 11'd0, 0, 0, 0, 0);
        run_dump(10'h123, 11'd32, 0, 0, 5, 0);
        run_dump(10'h010, 11'd2, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            run_dump(10'($urandom), 11'($urandom_range(1, 40)), 2, 1, 0, 0);
        end
        run_dump(10'($urandom), 11'd20, 0, 1, 0, 0);

        run_dump(10'h000, 11'd1024, 0, 0, 0, 1);
`ifdef ROM_CHECKSUM_EN
        s = 0;
        for (int i = 0; i < 1024; i++) s += int'(mem[i]);
        check("checksum", checksum, s & 16'hFFFF);
        repeat (3) @(negedge clk);
        #1;
        check("checksum_hold", checksum, s & 16'hFFFF);
`else
        s = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
